iot_filter_seq: RTL

//   Front-end sequencer for the IoT data-filter datapath. Packs a byte stream into 128-bit

---
 rtl/iot_filter_seq.sv | 138 +++++++++++++
 1 files changed

// File: rtl/iot_filter_seq.sv
// -----------------------------------------------------------------------------
// iot_filter_seq
//   Front-end sequencer for the IoT data-filter datapath. Packs an incoming
//   byte stream MSB-first into DATA_W-bit words (16 bytes per round), holds
//   each finished word for one EVAL cycle so the filter units can sample it,
//   and repeats for ROUNDS rounds per job before pulsing valid once.
//
// Handshake: a byte on iot_in is consumed on a rising edge where in_en=1 and
//   busy=0. While busy=1 (EVAL, NEXT, DONE) nothing is consumed and the host
//   must keep the byte stable until busy returns to 0.
//
// Ports
//   clk        in   1       system clock, rising edge
//   rst        in   1       synchronous active-high reset
//   in_en      in   1       iot_in carries a valid byte
//   iot_in     in   BYTE_W  input byte
//   fn_sel     in   3       filter function, captured at job start
//   busy       out  1       byte not accepted this cycle
//   data       out  DATA_W  packed word under construction / evaluation
//   cnt        out  6       bytes packed in the current round (0..16)
//   state      out  3       sequencer state code (debug-visible FSM state)
//   flag       out  1       0 in the first round of a job, 1 afterwards
//   cycle_cnt  out  8       rounds completed in the current job
//   fn_sel_q   out  3       fn_sel latched for the running job
//   valid      out  1       one-cycle pulse at job completion
// -----------------------------------------------------------------------------
module iot_filter_seq #(
  parameter int DATA_W = 128,
  parameter int BYTE_W = 8,
  parameter int ROUNDS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_en,
  input  logic [BYTE_W-1:0] iot_in,
  input  logic [2:0]        fn_sel,
  output logic              busy,
  output logic [DATA_W-1:0] data,
  output logic [5:0]        cnt,
  output logic [2:0]        state,
  output logic              flag,
  output logic [7:0]        cycle_cnt,
  output logic [2:0]        fn_sel_q,
  output logic              valid
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'b000,
    ST_LOAD = 3'b001,
    ST_EVAL = 3'b010,
    ST_NEXT = 3'b011,
    ST_DONE = 3'b100
  } state_e;

  localparam logic [7:0] ROUNDS_L = 8'(ROUNDS);

  state_e            state_q;
  logic [DATA_W-1:0] data_q;
  logic [5:0]        cnt_q;
  logic              flag_q;
  logic [7:0]        cycle_cnt_q;
  logic [2:0]        fn_sel_qq;
  logic              busy_q;
  logic              valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      data_q      <= '0;
      cnt_q       <= '0;
      flag_q      <= 1'b0;
      cycle_cnt_q <= '0;
      fn_sel_qq   <= '0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (in_en) begin
            data_q      <= {data_q[DATA_W-BYTE_W-1:0], iot_in};
            cnt_q       <= 6'd1;
            fn_sel_qq   <= fn_sel;
            flag_q      <= 1'b0;
            cycle_cnt_q <= 8'd0;
            state_q     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (in_en) begin
            data_q <= {data_q[DATA_W-BYTE_W-1:0], iot_in};
            cnt_q  <= cnt_q + 6'd1;
            // 16th byte of the round: word is complete, stop accepting.
            if (cnt_q == 6'd15) begin
              state_q <= ST_EVAL;
              busy_q  <= 1'b1;
            end
          end
        end
        ST_EVAL: begin
          state_q <= ST_NEXT;
        end
        ST_NEXT: begin
          cnt_q       <= 6'd0;
          cycle_cnt_q <= cycle_cnt_q + 8'd1;
          flag_q      <= 1'b1;
          if (cycle_cnt_q + 8'd1 == ROUNDS_L) begin
            state_q <= ST_DONE;
            valid_q <= 1'b1;
          end else begin
            state_q <= ST_LOAD;
            busy_q  <= 1'b0;
          end
        end
        ST_DONE: begin
          // cycle_cnt deliberately kept until the next job starts.
          state_q <= ST_IDLE;
          flag_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign data      = data_q;
  assign cnt       = cnt_q;
  assign state     = state_q;
  assign flag      = flag_q;
  assign cycle_cnt = cycle_cnt_q;
  assign fn_sel_q  = fn_sel_qq;
  assign valid     = valid_q;

endmodule
